// File: rtl/set_multi_scan.sv
// set_multi_scan: scans every lattice point (x,y) in 1..GRID of a square grid
// and counts the points that satisfy a set expression over three circles A, B, C.
// One job runs at a time: the host strobes en while idle, waits for the one-cycle
// valid pulse and then reads candidate, which holds until the next job is accepted.
module set_multi_scan #(
    parameter int  GRID = 8,
    parameter int  CW   = 4,
    parameter int  RW   = 4,
    localparam int CNTW = $clog2(GRID*GRID+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [6*CW-1:0]   central,
    input  logic [3*RW-1:0]   radius,
    input  logic [2:0]        mode,
    output logic              busy,
    output logic              valid,
    output logic [CNTW-1:0]   candidate
);

    // Distances and squared radii are compared at a common width so neither side truncates.
    localparam int DW   = 2*CW + 1;
    localparam int R2W  = 2*RW;
    localparam int CMPW = (DW > R2W) ? DW : R2W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CW-1:0] GRID_C = CW'(GRID);

    logic [1:0]      state;
    logic            drain_cnt;
    logic [CW-1:0]   x_pos;
    logic [CW-1:0]   y_pos;
    logic [6*CW-1:0] cen_q;
    logic [3*RW-1:0] rad_q;
    logic [2:0]      mode_q;

    logic            s1_valid;
    logic [DW-1:0]   d2_a, d2_b, d2_c;
    logic [R2W-1:0]  r2_a, r2_b, r2_c;

    logic            in_a, in_b, in_c;
    logic            hit;
    logic            last_point;

    // Squared Euclidean distance from a grid point to a centre. The square is
    // formed modulo 2**DW; since |dx| < 2**CW the true square always fits, so
    // the two's-complement product's low bits are exact.
    function automatic logic [DW-1:0] dist2(
        input logic [CW-1:0] px,
        input logic [CW-1:0] py,
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy
    );
        logic signed [CW:0] dx;
        logic signed [CW:0] dy;
        logic [DW-1:0]      ex;
        logic [DW-1:0]      ey;
        logic [DW-1:0]      sx;
        logic [DW-1:0]      sy;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({1'b0, cy});
        ex = {{CW{dx[CW]}}, dx};
        ey = {{CW{dy[CW]}}, dy};
        sx = ex * ex;
        sy = ey * ey;
        return sx + sy;
    endfunction

    // Square of an unsigned radius, widened first so the product is exact.
    function automatic logic [R2W-1:0] rsq(input logic [RW-1:0] r);
        logic [R2W-1:0] re;
        re = {{RW{1'b0}}, r};
        return re * re;
    endfunction

    assign last_point = (x_pos == GRID_C) && (y_pos == GRID_C);

    // Stage-2 membership tests on the registered distances, then the selected set expression.
    always_comb begin
        in_a = (CMPW'(d2_a) <= CMPW'(r2_a));
        in_b = (CMPW'(d2_b) <= CMPW'(r2_b));
        in_c = (CMPW'(d2_c) <= CMPW'(r2_c));
        hit  = 1'b0;
        case (mode_q)
            3'd0: hit = in_a;
            3'd1: hit = in_a & in_b;
            3'd2: hit = in_a ^ in_b;
            3'd3: hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
            3'd4: hit = in_a | in_b | in_c;
            3'd5: hit = in_a & in_b & in_c;
            3'd6: hit = in_a & ~in_b;
            3'd7: hit = in_a ^ in_b ^ in_c;
            default: hit = 1'b0;
        endcase
    end

    // Stage 1: register distance and squared radius of the point issued this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            d2_a     <= '0;
            d2_b     <= '0;
            d2_c     <= '0;
            r2_a     <= '0;
            r2_b     <= '0;
            r2_c     <= '0;
        end else begin
            s1_valid <= (state == SCAN);
            d2_a     <= dist2(x_pos, y_pos, cen_q[6*CW-1:5*CW], cen_q[5*CW-1:4*CW]);
            d2_b     <= dist2(x_pos, y_pos, cen_q[4*CW-1:3*CW], cen_q[3*CW-1:2*CW]);
            d2_c     <= dist2(x_pos, y_pos, cen_q[2*CW-1:CW],   cen_q[CW-1:0]);
            r2_a     <= rsq(rad_q[3*RW-1:2*RW]);
            r2_b     <= rsq(rad_q[2*RW-1:RW]);
            r2_c     <= rsq(rad_q[RW-1:0]);
        end
    end

    // Job control: accept, scan x inner / y outer, drain two edges, then pulse valid.
    // The candidate is cleared on accept and counts qualifying points at stage 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            x_pos     <= CW'(1);
            y_pos     <= CW'(1);
            cen_q     <= '0;
            rad_q     <= '0;
            mode_q    <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE && en) begin
                candidate <= '0;
            end else if (s1_valid && hit) begin
                candidate <= candidate + CNTW'(1);
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        cen_q  <= central;
                        rad_q  <= radius;
                        mode_q <= mode;
                        x_pos  <= CW'(1);
                        y_pos  <= CW'(1);
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (last_point) begin
                        x_pos     <= CW'(1);
                        y_pos     <= CW'(1);
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else if (x_pos == GRID_C) begin
                        x_pos <= CW'(1);
                        y_pos <= y_pos + CW'(1);
                    end else begin
                        x_pos <= x_pos + CW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_multi_scan.sv
// Directed bench for set_multi_scan at GRID=8, CW=4, RW=4 with hand-computed counts.
module tb_set_multi_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [2:0]  mode;
    logic        busy;
    logic        valid;
    logic [6:0]  candidate;

    int errors;
    int checks;

    set_multi_scan #(.GRID(8), .CW(4), .RW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] packC(input int xa, input int ya, input int xb,
                                          input int yb, input int xc, input int yc);
        return {4'(xa), 4'(ya), 4'(xb), 4'(yb), 4'(xc), 4'(yc)};
    endfunction

    function automatic logic [11:0] packR(input int ra, input int rb, input int rc);
        return {4'(ra), 4'(rb), 4'(rc)};
    endfunction

    // Present operands and strobe en for one edge; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m);
        central = c;
        radius  = r;
        mode    = m;
        en      = 1'b1;
        @(negedge clk);
        en      = 1'b0;
    endtask

    // Wait (bounded) for the valid pulse, counting cycles with busy high.
    task automatic waitDone(output int cnt, output int busyCycles, output bit gotValid);
        busyCycles = 0;
        gotValid   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (valid) begin
                gotValid = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
        cnt = int'(candidate);
    endtask

    task automatic runJob(input string tag, input logic [23:0] c, input logic [11:0] r,
                          input logic [2:0] m, input int exp);
        int  cnt;
        int  bc;
        bit  gv;
        applyStimulus(c, r, m);
        waitDone(cnt, bc, gv);
        checkOutput({tag, "_valid"}, int'(gv), 1);
        checkOutput(tag, cnt, exp);
    endtask

    initial begin
        int  cnt;
        int  bc;
        bit  gv;
        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        en      = 1'b0;
        central = '0;
        radius  = '0;
        mode    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_cand", int'(candidate), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single circle, latency and pulse width
        applyStimulus(packC(4, 4, 0, 0, 0, 0), packR(2, 0, 0), 3'd0);
        waitDone(cnt, bc, gv);
        checkOutput("m0_valid", int'(gv), 1);
        checkOutput("m0_cand", cnt, 13);
        checkOutput("m0_busy_cycles", bc, 66);
        checkOutput("m0_busy_at_valid", int'(busy), 0);
        @(negedge clk);
        checkOutput("m0_valid_one_cycle", int'(valid), 0);
        checkOutput("m0_cand_hold", int'(candidate), 13);

        // Two- and three-circle expressions
        runJob("m2", packC(3, 3, 4, 3, 0, 0), packR(1, 1, 0), 3'd2, 6);
        runJob("m1", packC(3, 3, 4, 3, 0, 0), packR(1, 1, 0), 3'd1, 2);
        runJob("m6", packC(3, 3, 4, 3, 0, 0), packR(1, 1, 0), 3'd6, 3);
        runJob("m3", packC(3, 3, 4, 3, 8, 8), packR(1, 1, 0), 3'd3, 2);
        runJob("m4", packC(3, 3, 4, 3, 8, 8), packR(1, 1, 0), 3'd4, 9);
        runJob("m7", packC(3, 3, 4, 3, 8, 8), packR(1, 1, 0), 3'd7, 7);
        runJob("m5", packC(3, 3, 4, 3, 8, 8), packR(1, 1, 0), 3'd5, 0);

        // Boundaries: off-grid centre, full grid, r=0 on grid
        runJob("offgrid", packC(0, 0, 0, 0, 0, 0), packR(1, 0, 0), 3'd0, 0);
        runJob("fullgrid", packC(8, 8, 0, 0, 0, 0), packR(15, 0, 0), 3'd0, 64);
        runJob("r0", packC(5, 2, 0, 0, 0, 0), packR(0, 0, 0), 3'd0, 1);

        // en mid-scan with different operands is ignored
        applyStimulus(packC(4, 4, 0, 0, 0, 0), packR(2, 0, 0), 3'd0);
        repeat (20) @(negedge clk);
        applyStimulus(packC(8, 8, 0, 0, 0, 0), packR(15, 0, 0), 3'd0);
        waitDone(cnt, bc, gv);
        checkOutput("ignore_valid", int'(gv), 1);
        checkOutput("ignore_cand", cnt, 13);
        checkOutput("ignore_busy_cycles", bc, 45);

        // en in the valid cycle starts the next job and clears the count
        applyStimulus(packC(3, 3, 4, 3, 0, 0), packR(1, 1, 0), 3'd2);
        checkOutput("b2b_busy", int'(busy), 1);
        checkOutput("b2b_cand_clear", int'(candidate), 0);
        waitDone(cnt, bc, gv);
        checkOutput("b2b_valid", int'(gv), 1);
        checkOutput("b2b_cand", cnt, 6);

        // Asynchronous reset mid-scan
        @(negedge clk);
        applyStimulus(packC(8, 8, 0, 0, 0, 0), packR(15, 0, 0), 3'd0);
        repeat (30) @(negedge clk);
        checkOutput("pre_rst_cand_nonzero", int'(candidate != 0), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_cand", int'(candidate), 0);
        gv = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (valid) gv = 1'b1;
        end
        checkOutput("rst_no_valid", int'(gv), 0);
        rst = 1'b1;
        @(negedge clk);
        gv = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (valid || busy) gv = 1'b1;
        end
        checkOutput("rst_abandoned", int'(gv), 0);
        runJob("post_rst", packC(4, 4, 0, 0, 0, 0), packR(2, 0, 0), 3'd0, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
